// File: rtl/simd_pkg.sv
// Shared types and sizes for the SIMD processor front end.
package simd_pkg;

  localparam int INSTR_W    = 32;
  localparam int IMEM_DEPTH = 256;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage : simd_pkg

// File: rtl/pc_counter.sv
// Modulo-N up-counter with synchronous active-high reset and count enable.
module pc_counter #(
  parameter int N = 256,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  output logic [W-1:0] CNT
);

  localparam logic [W-1:0] CNT_MAX = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_next;

  // Explicit terminal compare keeps the wrap correct even if N is ever non-power-of-two.
  always_comb begin
    cnt_next = cnt_q;
    if (EN) begin
      if (cnt_q == CNT_MAX) cnt_next = '0;
      else                  cnt_next = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_next;
  end

  assign CNT = cnt_q;

endmodule : pc_counter

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC (fetch address) and the fetched-instruction holding register.
module instr_fetch_unit
  import simd_pkg::*;
#(
  parameter int N = IMEM_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 PC_INCR,
  input  logic                 INSTR_DONE,
  input  logic [INSTR_W-1:0]   INSTR_AXI,
  output logic [$clog2(N)-1:0] PC_AXI,
  output logic [INSTR_W-1:0]   INSTR
);

  localparam int PC_W = $clog2(N);

  instr_t           instr_q;
  logic [PC_W-1:0]  pc_q;

  // RSTN is active-high despite its name; the name is kept for existing callers.
  pc_counter #(
    .N (N),
    .W (PC_W)
  ) u_pc_counter (
    .CLK (CLK),
    .RST (RSTN),
    .EN  (PC_INCR),
    .CNT (pc_q)
  );

  always_ff @(posedge CLK) begin
    if (RSTN)            instr_q <= '0;
    else if (INSTR_DONE) instr_q <= INSTR_AXI;
  end

  assign PC_AXI = pc_q;
  assign INSTR  = instr_q;

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, increment/capture, hold, wrap, mid-run reset.
module tb_instr_fetch_unit;

  localparam int N    = 256;
  localparam int PC_W = $clog2(N);

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             PC_INCR;
  logic             INSTR_DONE;
  logic [31:0]      INSTR_AXI;
  logic [PC_W-1:0]  PC_AXI;
  logic [31:0]      INSTR;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit #(.N(N)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .PC_INCR    (PC_INCR),
    .INSTR_DONE (INSTR_DONE),
    .INSTR_AXI  (INSTR_AXI),
    .PC_AXI     (PC_AXI),
    .INSTR      (INSTR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic incr, input logic done, input logic [31:0] axi);
    RSTN       = rst;
    PC_INCR    = incr;
    INSTR_DONE = done;
    INSTR_AXI  = axi;
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0007);
    tick();
    check("rst_pc", 32'(PC_AXI), 32'd0);
    check("rst_instr", INSTR, 32'h0);

    drive(1'b0, 1'b1, 1'b1, 32'd5);
    tick();
    check("inc1_pc", 32'(PC_AXI), 32'd1);
    check("inc1_instr", INSTR, 32'd5);
    tick();
    check("inc2_pc", 32'(PC_AXI), 32'd2);
    check("inc2_instr", INSTR, 32'd5);

    drive(1'b0, 1'b0, 1'b1, 32'd6);
    tick();
    check("hold1_pc", 32'(PC_AXI), 32'd2);
    check("hold1_instr", INSTR, 32'd6);
    tick();
    check("hold2_pc", 32'(PC_AXI), 32'd2);
    check("hold2_instr", INSTR, 32'd6);

    drive(1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    tick();
    check("idle_pc", 32'(PC_AXI), 32'd2);
    check("idle_instr", INSTR, 32'd6);

    drive(1'b0, 1'b0, 1'b0, 32'hxxxx_xxxx);
    tick();
    check("x_blocked_instr", INSTR, 32'd6);

    // Capture with increment takes the word for the old PC.
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0102);
    tick();
    check("both_pc", 32'(PC_AXI), 32'd3);
    check("both_instr", INSTR, 32'h0000_0102);

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    check("wrap_rst_pc", 32'(PC_AXI), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i < N; i++) begin
      tick();
      check("wrap_step_pc", 32'(PC_AXI), 32'(i));
    end
    check("wrap_top_pc", 32'(PC_AXI), 32'd255);
    tick();
    check("wrap_zero_pc", 32'(PC_AXI), 32'd0);
    tick();
    check("wrap_one_pc", 32'(PC_AXI), 32'd1);
    check("wrap_instr", INSTR, 32'h0);

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (36) tick();
    drive(1'b0, 1'b1, 1'b1, 32'd9);
    tick();
    check("mid_pc", 32'(PC_AXI), 32'd37);
    check("mid_instr", INSTR, 32'd9);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0055);
    tick();
    check("mid_rst_pc", 32'(PC_AXI), 32'd0);
    check("mid_rst_instr", INSTR, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0077);
    tick();
    check("resume_pc", 32'(PC_AXI), 32'd1);
    check("resume_instr", INSTR, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instr_fetch_unit
